video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 54 +++++
 rtl/video_pattern_gen.sv | 96 +++++++++
 rtl/video_timing_gen.sv | 226 ++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: default 720p60 timing,
// test-pattern encodings and colour-bar palette.
package video_timing_pkg;

  // CEA-861 1280x720p60 timing at 74.25 MHz
  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 110;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;

  // Coordinate widths exported on pix_x / pix_y
  localparam int X_W = 11;
  localparam int Y_W = 10;

  // Test-pattern selector encodings
  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  // Colour-bar palette, {r,g,b}
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Map a bar index (0 = leftmost) to its colour
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      3'd7:    c = RGB_BLACK;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Output stage: turns the decoded raster position into test-pattern colour
// and registers every output together so colour, syncs, de, coordinates and
// the frame strobe leave on the same clock edge.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int SYNC_POL = 1
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              de,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              sof,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [2:0]        bar_idx,
  input  logic [7:0]        frame_cnt,
  input  logic [1:0]        pattern,
  input  logic [23:0]       solid_rgb,
  output logic [7:0]        video_r,
  output logic [7:0]        video_g,
  output logic [7:0]        video_b,
  output logic              video_de,
  output logic              video_hsync,
  output logic              video_vsync,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              frame_start
);

  // Electrical level of an asserted sync; idle level is its complement
  localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [23:0] rgb_s;
  logic        hsync_lvl_s;
  logic        vsync_lvl_s;

  // Pattern colour for the current pixel, black whenever de is low
  always_comb begin
    rgb_s = RGB_BLACK;
    if (de) begin
      case (pattern)
        PAT_BARS:  rgb_s = bar_colour(bar_idx);
        PAT_GRAD:  rgb_s = {x[7:0], y[7:0], frame_cnt};
        PAT_SOLID: rgb_s = solid_rgb;
        PAT_CHECK: rgb_s = (x[5] ^ y[5]) ? RGB_WHITE : RGB_BLACK;
        default:   rgb_s = RGB_BLACK;
      endcase
    end else begin
      rgb_s = RGB_BLACK;
    end
  end

  // Translate logical sync assertion into the configured output polarity
  always_comb begin
    hsync_lvl_s = ~SYNC_ON;
    vsync_lvl_s = ~SYNC_ON;
    if (hsync) begin
      hsync_lvl_s = SYNC_ON;
    end else begin
      hsync_lvl_s = ~SYNC_ON;
    end
    if (vsync) begin
      vsync_lvl_s = SYNC_ON;
    end else begin
      vsync_lvl_s = ~SYNC_ON;
    end
  end

  // Output register: all video outputs update together
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      video_r     <= 8'd0;
      video_g     <= 8'd0;
      video_b     <= 8'd0;
      video_de    <= 1'b0;
      video_hsync <= ~SYNC_ON;
      video_vsync <= ~SYNC_ON;
      pix_x       <= {X_W{1'b0}};
      pix_y       <= {Y_W{1'b0}};
      frame_start <= 1'b0;
    end else begin
      video_r     <= rgb_s[23:16];
      video_g     <= rgb_s[15:8];
      video_b     <= rgb_s[7:0];
      video_de    <= de;
      video_hsync <= hsync_lvl_s;
      video_vsync <= vsync_lvl_s;
      pix_x       <= de ? x : {X_W{1'b0}};
      pix_y       <= de ? y : {Y_W{1'b0}};
      frame_start <= sof;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the HDMI transmit path. Stage 0 runs the
// horizontal/vertical counters, stage 1 decodes them into de/syncs/coords
// and tracks the colour-bar index, stage 2 (video_pattern_gen) produces
// the registered outputs. Counter state reaches the outputs 2 cycles later.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACTIVE = V_ACTIVE_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720,
  parameter int SYNC_POL = 1
) (
  input  logic           clk_pixel,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [1:0]     pattern_sel,
  input  logic [23:0]    solid_rgb,
  output logic [7:0]     video_r,
  output logic [7:0]     video_g,
  output logic [7:0]     video_b,
  output logic           video_de,
  output logic           video_hsync,
  output logic           video_vsync,
  output logic [10:0]    pix_x,
  output logic [9:0]     pix_y,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_START   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END     = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] BAR_LAST   = X_W'(H_ACTIVE / 8 - 1);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_START   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END     = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0 state
  logic [X_W-1:0] h_cnt_r;
  logic [Y_W-1:0] v_cnt_r;
  logic [7:0]     frame_cnt_r;
  logic [1:0]     pattern_r;
  logic           h_wrap_s;
  logic           v_wrap_s;
  logic           origin_s;

  // Stage 1 decode
  logic           de_s;
  logic           hsync_s;
  logic           vsync_s;
  logic           sof_s;
  logic           de_r;
  logic           hsync_r;
  logic           vsync_r;
  logic           sof_r;
  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;

  // Colour-bar tracking, aligned with stage 1
  logic [X_W-1:0] bar_cnt_s;
  logic [2:0]     bar_idx_s;
  logic [X_W-1:0] bar_cnt_r;
  logic [2:0]     bar_idx_r;

  // Wrap and origin detection on the raw counters
  always_comb begin
    h_wrap_s = 1'b0;
    v_wrap_s = 1'b0;
    origin_s = 1'b0;
    if (h_cnt_r == H_LAST) begin
      h_wrap_s = 1'b1;
    end else begin
      h_wrap_s = 1'b0;
    end
    if (v_cnt_r == V_LAST) begin
      v_wrap_s = 1'b1;
    end else begin
      v_wrap_s = 1'b0;
    end
    if ((h_cnt_r == {X_W{1'b0}}) && (v_cnt_r == {Y_W{1'b0}})) begin
      origin_s = 1'b1;
    end else begin
      origin_s = 1'b0;
    end
  end

  // Pixel and line counters; disabled raster is parked at the origin
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= {X_W{1'b0}};
      v_cnt_r <= {Y_W{1'b0}};
    end else if (!enable) begin
      h_cnt_r <= {X_W{1'b0}};
      v_cnt_r <= {Y_W{1'b0}};
    end else if (h_wrap_s) begin
      h_cnt_r <= {X_W{1'b0}};
      if (v_wrap_s) begin
        v_cnt_r <= {Y_W{1'b0}};
      end else begin
        v_cnt_r <= v_cnt_r + Y_W'(1);
      end
    end else begin
      h_cnt_r <= h_cnt_r + X_W'(1);
    end
  end

  // Frame counter steps as the raster wraps so a whole frame shares one value
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 8'd0;
    end else if (enable && h_wrap_s && v_wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Pattern selection is sampled only at the origin so frames never tear
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= PAT_BARS;
    end else if (origin_s) begin
      pattern_r <= pattern_sel;
    end else begin
      pattern_r <= pattern_r;
    end
  end

  // Active-area and sync window decode, all blanked while disabled
  always_comb begin
    de_s    = 1'b0;
    hsync_s = 1'b0;
    vsync_s = 1'b0;
    sof_s   = 1'b0;
    if (enable) begin
      de_s    = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
      hsync_s = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
      vsync_s = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
      sof_s   = origin_s;
    end else begin
      de_s    = 1'b0;
      hsync_s = 1'b0;
      vsync_s = 1'b0;
      sof_s   = 1'b0;
    end
  end

  // Bar index advances every H_ACTIVE/8 pixels and saturates on the last bar
  always_comb begin
    bar_cnt_s = bar_cnt_r;
    bar_idx_s = bar_idx_r;
    if (h_cnt_r == {X_W{1'b0}}) begin
      bar_cnt_s = {X_W{1'b0}};
      bar_idx_s = 3'd0;
    end else if (bar_cnt_r == BAR_LAST) begin
      bar_cnt_s = {X_W{1'b0}};
      if (bar_idx_r == 3'd7) begin
        bar_idx_s = 3'd7;
      end else begin
        bar_idx_s = bar_idx_r + 3'd1;
      end
    end else begin
      bar_cnt_s = bar_cnt_r + X_W'(1);
      bar_idx_s = bar_idx_r;
    end
  end

  // Stage 1 register: decoded timing plus coordinates of the same pixel
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      de_r      <= 1'b0;
      hsync_r   <= 1'b0;
      vsync_r   <= 1'b0;
      sof_r     <= 1'b0;
      x_r       <= {X_W{1'b0}};
      y_r       <= {Y_W{1'b0}};
      bar_cnt_r <= {X_W{1'b0}};
      bar_idx_r <= 3'd0;
    end else begin
      de_r      <= de_s;
      hsync_r   <= hsync_s;
      vsync_r   <= vsync_s;
      sof_r     <= sof_s;
      x_r       <= de_s ? h_cnt_r : {X_W{1'b0}};
      y_r       <= de_s ? v_cnt_r : {Y_W{1'b0}};
      bar_cnt_r <= bar_cnt_s;
      bar_idx_r <= bar_idx_s;
    end
  end

  video_pattern_gen #(
    .SYNC_POL (SYNC_POL)
  ) u_pattern (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .de          (de_r),
    .hsync       (hsync_r),
    .vsync       (vsync_r),
    .sof         (sof_r),
    .x           (x_r),
    .y           (y_r),
    .bar_idx     (bar_idx_r),
    .frame_cnt   (frame_cnt_r),
    .pattern     (pattern_r),
    .solid_rgb   (solid_rgb),
    .video_r     (video_r),
    .video_g     (video_g),
    .video_b     (video_b),
    .video_de    (video_de),
    .video_hsync (video_hsync),
    .video_vsync (video_vsync),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start)
  );

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced raster
// (320+8+8+16 = 352 pixels, 12+2+2+2 = 18 lines) so whole frames are short.
// A second instance with SYNC_POL=0 runs in lockstep for sync polarity.
module tb_video_timing_gen;

  localparam int HT    = 352;
  localparam int VT    = 18;
  localparam int FRAME = HT * VT;

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h123456;

  logic [7:0]  video_r, video_g, video_b;
  logic        video_de, video_hsync, video_vsync, video_frame_start;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  logic [7:0]  n_r, n_g, n_b;
  logic        n_de, n_hsync, n_vsync, n_frame_start;
  logic [10:0] n_pix_x;
  logic [9:0]  n_pix_y;

  logic [23:0] rgb;
  assign rgb = {video_r, video_g, video_b};

  int n_cmp = 0;
  int n_fail = 0;
  int pos = 0;
  int fs_seen = 0;
  int fs_bad = 0;

  always #5 clk_pixel = ~clk_pixel;

  video_timing_gen #(
    .H_ACTIVE(320), .H_FP(8), .H_SYNC(8), .H_BP(16),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1)
  ) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .video_r(video_r), .video_g(video_g), .video_b(video_b),
    .video_de(video_de), .video_hsync(video_hsync), .video_vsync(video_vsync),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(video_frame_start)
  );

  video_timing_gen #(
    .H_ACTIVE(320), .H_FP(8), .H_SYNC(8), .H_BP(16),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(0)
  ) dut_n (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .video_r(n_r), .video_g(n_g), .video_b(n_b),
    .video_de(n_de), .video_hsync(n_hsync), .video_vsync(n_vsync),
    .pix_x(n_pix_x), .pix_y(n_pix_y), .frame_start(n_frame_start)
  );

  // Advance one cycle; outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk_pixel);
    pos++;
    if (video_frame_start) begin
      fs_seen++;
      if (!(video_de && pix_x == 11'd0 && pix_y == 10'd0)) fs_bad++;
    end
  endtask

  // Advance until the outputs show pixel (v,h) of frame f (2-cycle latency)
  task automatic go(input int f, input int v, input int h);
    int t;
    t = f * FRAME + v * HT + h + 2;
    while (pos < t) step();
  endtask

  // Reset pulse, then release with enable high and the given pattern
  task automatic restart(input logic [1:0] sel);
    @(negedge clk_pixel);
    rst_n = 1'b0;
    enable = 1'b1;
    pattern_sel = sel;
    @(negedge clk_pixel);
    rst_n = 1'b1;
    pos = 0;
    fs_seen = 0;
    fs_bad = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_pixel);
    rst_n = 1'b0;
    enable = 1'b1;
    @(negedge clk_pixel);
    n_cmp++; if (rgb !== 24'h000000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000000", rgb); end
    n_cmp++; if ({video_de, video_hsync, video_vsync, video_frame_start} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {video_de, video_hsync, video_vsync, video_frame_start}); end
    n_cmp++; if ({pix_x, pix_y} !== 21'd0) begin n_fail++; $display("FAIL reset_pix: got %0d,%0d expected 0,0", pix_x, pix_y); end
    n_cmp++; if ({n_hsync, n_vsync} !== 2'b11) begin n_fail++; $display("FAIL reset_neg_sync: got %b expected 11", {n_hsync, n_vsync}); end
  endtask

  task automatic test_timing();
    int de_hi, hs_first, hs_len;
    de_hi = 0; hs_first = -1; hs_len = 0;
    restart(2'd0);
    step();
    n_cmp++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL de_latency1: got %b expected 0", video_de); end
    step();
    n_cmp++; if ({video_de, video_frame_start} !== 2'b11) begin n_fail++; $display("FAIL de_first: got %b expected 11", {video_de, video_frame_start}); end
    for (int i = 0; i < HT; i++) begin
      if (video_de) de_hi++;
      if (video_hsync) begin
        if (hs_first < 0) hs_first = i;
        hs_len++;
      end
      if (i == 328) begin
        n_cmp++; if (n_hsync !== 1'b0) begin n_fail++; $display("FAIL neg_hsync_active: got %b expected 0", n_hsync); end
      end
      step();
    end
    n_cmp++; if (de_hi !== 320) begin n_fail++; $display("FAIL de_width: got %0d expected 320", de_hi); end
    n_cmp++; if (hs_first !== 328) begin n_fail++; $display("FAIL hsync_start: got %0d expected 328", hs_first); end
    n_cmp++; if (hs_len !== 8) begin n_fail++; $display("FAIL hsync_width: got %0d expected 8", hs_len); end
    n_cmp++; if ({video_de, pix_y} !== {1'b1, 10'd1}) begin n_fail++; $display("FAIL line_period: got de=%b y=%0d expected de=1 y=1", video_de, pix_y); end
    go(0, 13, HT - 1);
    n_cmp++; if (video_vsync !== 1'b0) begin n_fail++; $display("FAIL vsync_before: got %b expected 0", video_vsync); end
    go(0, 14, 0);
    n_cmp++; if ({video_vsync, n_vsync} !== 2'b10) begin n_fail++; $display("FAIL vsync_start: got %b expected 10", {video_vsync, n_vsync}); end
    go(0, 15, HT - 1);
    n_cmp++; if (video_vsync !== 1'b1) begin n_fail++; $display("FAIL vsync_last: got %b expected 1", video_vsync); end
    go(0, 16, 0);
    n_cmp++; if (video_vsync !== 1'b0) begin n_fail++; $display("FAIL vsync_after: got %b expected 0", video_vsync); end
    go(0, VT - 1, HT - 1);
    n_cmp++; if (video_frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_early: got %b expected 0", video_frame_start); end
    go(1, 0, 0);
    n_cmp++; if ({video_frame_start, video_de} !== 2'b11) begin n_fail++; $display("FAIL frame_period: got %b expected 11", {video_frame_start, video_de}); end
    n_cmp++; if (fs_seen !== 2) begin n_fail++; $display("FAIL fs_count: got %0d expected 2", fs_seen); end
  endtask

  task automatic test_bars();
    restart(2'd0);
    go(0, 3, 0);
    n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL bar_x0: got %h expected FFFFFF", rgb); end
    go(0, 3, 39);
    n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL bar_x39: got %h expected FFFFFF", rgb); end
    go(0, 3, 40);
    n_cmp++; if (rgb !== 24'hFFFF00) begin n_fail++; $display("FAIL bar_x40: got %h expected FFFF00", rgb); end
    go(0, 3, 160);
    n_cmp++; if (rgb !== 24'hFF00FF) begin n_fail++; $display("FAIL bar_x160: got %h expected FF00FF", rgb); end
    go(0, 3, 240);
    n_cmp++; if (rgb !== 24'h0000FF) begin n_fail++; $display("FAIL bar_x240: got %h expected 0000FF", rgb); end
    go(0, 3, 319);
    n_cmp++; if ({video_de, rgb, pix_x, pix_y} !== {1'b1, 24'h000000, 11'd319, 10'd3}) begin n_fail++; $display("FAIL bar_x319: got de=%b rgb=%h x=%0d y=%0d expected 1 000000 319 3", video_de, rgb, pix_x, pix_y); end
    go(0, 3, 325);
    n_cmp++; if ({video_de, rgb, pix_x, pix_y} !== {1'b0, 24'h000000, 11'd0, 10'd0}) begin n_fail++; $display("FAIL bar_blank: got de=%b rgb=%h x=%0d y=%0d expected 0 000000 0 0", video_de, rgb, pix_x, pix_y); end
  endtask

  task automatic test_pattern_switch();
    restart(2'd0);
    go(0, 5, 0);
    pattern_sel = 2'd3;
    go(0, 5, 200);
    n_cmp++; if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL switch_same_frame: got %h expected FF0000", rgb); end
    go(0, 10, 0);
    n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL switch_late_line: got %h expected FFFFFF", rgb); end
    go(1, 0, 0);
    n_cmp++; if ({video_de, rgb} !== {1'b1, 24'h000000}) begin n_fail++; $display("FAIL check_0_0: got de=%b rgb=%h expected 1 000000", video_de, rgb); end
    go(1, 0, 32);
    n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL check_32_0: got %h expected FFFFFF", rgb); end
    go(1, 1, 96);
    n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL check_96_1: got %h expected FFFFFF", rgb); end
  endtask

  task automatic test_gradient();
    restart(2'd1);
    go(0, 5, 300);
    n_cmp++; if (rgb !== 24'h2C0500) begin n_fail++; $display("FAIL grad_f0: got %h expected 2C0500", rgb); end
    go(1, 0, 10);
    n_cmp++; if (rgb !== 24'h0A0001) begin n_fail++; $display("FAIL grad_f1: got %h expected 0A0001", rgb); end
    go(2, 5, 300);
    n_cmp++; if (rgb !== 24'h2C0502) begin n_fail++; $display("FAIL grad_f2: got %h expected 2C0502", rgb); end
    n_cmp++; if (fs_seen !== 3) begin n_fail++; $display("FAIL grad_fs_count: got %0d expected 3", fs_seen); end
    n_cmp++; if (fs_bad !== 0) begin n_fail++; $display("FAIL grad_fs_align: got %0d misaligned expected 0", fs_bad); end
  endtask

  task automatic test_reset_mid();
    restart(2'd0);
    go(0, 8, 100);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({video_de, rgb, pix_x, pix_y} !== 46'd0) begin n_fail++; $display("FAIL midrst_active: got de=%b rgb=%h x=%0d y=%0d expected all 0", video_de, rgb, pix_x, pix_y); end
    restart(2'd0);
    go(0, 14, 330);
    n_cmp++; if ({video_hsync, video_vsync} !== 2'b11) begin n_fail++; $display("FAIL midrst_pre_sync: got %b expected 11", {video_hsync, video_vsync}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({video_hsync, video_vsync, n_hsync, n_vsync} !== 4'b0011) begin n_fail++; $display("FAIL midrst_sync: got %b expected 0011", {video_hsync, video_vsync, n_hsync, n_vsync}); end
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    restart(2'd0);
    go(0, 2, 50);
    enable = 1'b0;
    step();
    step();
    n_cmp++; if ({video_de, video_hsync} !== 2'b00) begin n_fail++; $display("FAIL dis_blank: got %b expected 00", {video_de, video_hsync}); end
    for (int i = 0; i < 400; i++) begin
      step();
      if (video_de || video_frame_start || video_hsync || video_vsync) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL dis_hold: got %0d active cycles expected 0", bad); end
    enable = 1'b1;
    pos = 0;
    step();
    n_cmp++; if (video_de !== 1'b0) begin n_fail++; $display("FAIL reen_lat: got %b expected 0", video_de); end
    step();
    n_cmp++; if ({video_de, video_frame_start, pix_x, pix_y} !== {2'b11, 21'd0}) begin n_fail++; $display("FAIL reen_origin: got de=%b fs=%b x=%0d y=%0d expected 1 1 0 0", video_de, video_frame_start, pix_x, pix_y); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_pattern_switch();
    test_gradient();
    test_reset_mid();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
